// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: level/edge pending capture, per-source enable, fixed-priority
// arbitration (bit 0 highest) and a claim/complete handshake through the CLAIM register.
module apb_irq_ctrl #(
   parameter int unsigned APB_ADDR_WIDTH = 12,
   parameter int unsigned NUM_SRC        = 8
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   input  logic [NUM_SRC-1:0]        irq_src_i,
   output logic                      irq_o,
   output logic [4:0]                irq_id_o
);

   localparam logic [7:0] OffPending = 8'h00;
   localparam logic [7:0] OffEnable  = 8'h04;
   localparam logic [7:0] OffEdge    = 8'h08;
   localparam logic [7:0] OffClaim   = 8'h0C;
   localparam logic [7:0] OffPendClr = 8'h10;

   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] in_service_q, in_service_d;
   logic [NUM_SRC-1:0] enable_q, enable_d;
   logic [NUM_SRC-1:0] edge_q, edge_d;
   logic               acc_q;
   logic               irq_q, irq_d;
   logic [4:0]         irq_id_q, irq_id_d;

   logic [7:0]         addr;
   logic               hit_pending, hit_enable, hit_edge, hit_claim, hit_pclr, mapped;
   logic               access, strobe, wr_stb, rd_stb;
   logic [NUM_SRC-1:0] eligible, rise, claim_mask, complete_mask, pclr_mask;
   logic [4:0]         win_id;
   logic               unused_paddr;

   // Only the low byte is decoded; upper address bits alias.
   assign addr         = PADDR[7:0];
   assign unused_paddr = ^PADDR;

   assign hit_pending = (addr == OffPending);
   assign hit_enable  = (addr == OffEnable);
   assign hit_edge    = (addr == OffEdge);
   assign hit_claim   = (addr == OffClaim);
   assign hit_pclr    = (addr == OffPendClr);
   assign mapped      = hit_pending | hit_enable | hit_edge | hit_claim | hit_pclr;

   // Side effects fire once per access phase, however long the master holds it.
   assign access = PSEL & PENABLE;
   assign strobe = access & ~acc_q;
   assign wr_stb = strobe & PWRITE;
   assign rd_stb = strobe & ~PWRITE;

   assign eligible = pending_q & enable_q & ~in_service_q;
   assign rise     = irq_src_i & ~src_q;

   always_comb begin
      win_id = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_id = 5'(i + 1);
         end
      end
   end

   always_comb begin
      claim_mask    = '0;
      complete_mask = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         claim_mask[i]    = rd_stb & hit_claim & (win_id == 5'(i + 1));
         complete_mask[i] = wr_stb & hit_claim & (PWDATA == 32'(i + 1));
      end
   end

   assign pclr_mask = (wr_stb & hit_pclr) ? PWDATA[NUM_SRC-1:0] : '0;

   // Edge sources: a fresh rising edge beats a same-cycle claim or W1C.
   always_comb begin
      pending_d    = (edge_q & (rise | (pending_q & ~(claim_mask | pclr_mask))))
                   | (~edge_q & irq_src_i);
      in_service_d = (in_service_q | claim_mask) & ~complete_mask;
      enable_d     = (wr_stb & hit_enable) ? PWDATA[NUM_SRC-1:0] : enable_q;
      edge_d       = (wr_stb & hit_edge) ? PWDATA[NUM_SRC-1:0] : edge_q;
      irq_d        = |eligible;
      irq_id_d     = win_id;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         src_q        <= '0;
         pending_q    <= '0;
         in_service_q <= '0;
         enable_q     <= '0;
         edge_q       <= '0;
         acc_q        <= 1'b0;
         irq_q        <= 1'b0;
         irq_id_q     <= '0;
      end else begin
         src_q        <= irq_src_i;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
         enable_q     <= enable_d;
         edge_q       <= edge_d;
         acc_q        <= access;
         irq_q        <= irq_d;
         irq_id_q     <= irq_id_d;
      end
   end

   always_comb begin
      PRDATA = '0;
      if (PSEL) begin
         case (addr)
            OffPending: PRDATA = 32'(pending_q);
            OffEnable:  PRDATA = 32'(enable_q);
            OffEdge:    PRDATA = 32'(edge_q);
            OffClaim:   PRDATA = 32'(win_id);
            default:    PRDATA = '0;
         endcase
      end
   end

   assign PREADY   = 1'b1;
   assign PSLVERR  = access & ~mapped;
   assign irq_o    = irq_q;
   assign irq_id_o = irq_id_q;

   a_id_tracks_irq: assert property (@(posedge HCLK) disable iff (!HRESETn)
      irq_o == (irq_id_o != 5'd0));
   a_claim_not_in_service: assert property (@(posedge HCLK) disable iff (!HRESETn)
      (claim_mask & in_service_q) == '0);

endmodule
